// File: rtl/riscv_types.sv
// riscv_types: shared RISC-V AMO opcode and responder state encodings.
package riscv_types;
  typedef enum logic [4:0] {
    AMO_ADD  = 5'b00000,
    AMO_SWAP = 5'b00001,
    AMO_LR   = 5'b00010,
    AMO_SC   = 5'b00011,
    AMO_XOR  = 5'b00100,
    AMO_OR   = 5'b01000,
    AMO_AND  = 5'b01100,
    AMO_MIN  = 5'b10000,
    AMO_MAX  = 5'b10100,
    AMO_MINU = 5'b11000,
    AMO_MAXU = 5'b11100
  } amo_t;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} amo_state_t;
  function automatic logic is_amo(input logic [4:0] op);
    case (op)
      AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: is_amo = 1'b1;
      default: is_amo = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/amo_alu.sv
// amo_alu: combinational AMO read-modify-write function; SWAP and SC pass wdata through.
module amo_alu
  import riscv_types::*;
(
  input  amo_t        op,
  input  logic [31:0] old,
  input  logic [31:0] wdata,
  output logic [31:0] result
);
  always_comb begin
    result = wdata;
    case (op)
      AMO_ADD:  result = old + wdata;
      AMO_XOR:  result = old ^ wdata;
      AMO_AND:  result = old & wdata;
      AMO_OR:   result = old | wdata;
      AMO_MIN:  result = $signed(old) < $signed(wdata) ? old : wdata;
      AMO_MAX:  result = $signed(old) > $signed(wdata) ? old : wdata;
      AMO_MINU: result = old < wdata ? old : wdata;
      AMO_MAXU: result = old > wdata ? old : wdata;
      default:  result = wdata;
    endcase
  end
endmodule

// File: rtl/amo_responder.sv
// amo_responder: single-outstanding AMO engine doing read-modify-write against memory.
// Define AMO_LRSC_EN for LR/SC reservation tracking; otherwise SC always fails.
module amo_responder
  import riscv_types::*;
#(
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [ID_W-1:0] req_id,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic [ID_W-1:0] rsp_id,
  output logic            rsp_err,
  output logic            mem_rd_req,
  input  logic            mem_rd_ack,
  input  logic [31:0]     mem_rdata,
  output logic            mem_wr_req,
  input  logic            mem_wr_ack,
  output logic [31:0]     mem_wdata,
  output logic [31:0]     mem_addr,
  input  logic            snoop_wr_valid,
  input  logic [31:0]     snoop_wr_addr
);
  amo_state_t state_q, state_d;
  amo_t op_q;
  logic [29:0] word_q;
  logic [31:0] wdata_q, rdata_q, alu_result;
  logic [ID_W-1:0] id_q;
  logic err_q, accept, bad, is_sc, sc_ok;
  assign req_ready = state_q == IDLE;
  assign accept = req_valid && req_ready;
  assign bad = |req_addr[1:0] || !is_amo(req_op);
  assign is_sc = req_op == AMO_SC;
`ifdef AMO_LRSC_EN
  logic resv_v;
  logic [29:0] resv_w;
  logic unused_snoop_lsb;
  assign unused_snoop_lsb = ^snoop_wr_addr[1:0];
  // a snoop landing on the same cycle as the SC still kills it
  assign sc_ok = resv_v && resv_w == req_addr[31:2] &&
                 !(snoop_wr_valid && snoop_wr_addr[31:2] == req_addr[31:2]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      resv_v <= 1'b0;
      resv_w <= '0;
    end else if (accept && is_sc) begin
      resv_v <= 1'b0;
    end else if (state_q == READ && mem_rd_ack && op_q == AMO_LR) begin
      resv_v <= !(snoop_wr_valid && snoop_wr_addr[31:2] == word_q);
      resv_w <= word_q;
    end else if (snoop_wr_valid && snoop_wr_addr[31:2] == resv_w) begin
      resv_v <= 1'b0;
    end
`else
  logic unused_snoop;
  assign unused_snoop = ^{snoop_wr_valid, snoop_wr_addr};
  assign sc_ok = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = bad ? RESP : is_sc ? (sc_ok ? WRITE : RESP) : READ;
      READ:    if (mem_rd_ack) state_d = op_q == AMO_LR ? RESP : WRITE;
      WRITE:   if (mem_wr_ack) state_d = RESP;
      default: if (rsp_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= AMO_ADD;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= amo_t'(req_op);
        word_q  <= req_addr[31:2];
        wdata_q <= req_wdata;
        id_q    <= req_id;
        err_q   <= bad;
        rdata_q <= {31'b0, !bad && is_sc && !sc_ok};
      end
      if (state_q == READ && mem_rd_ack) rdata_q <= mem_rdata;
    end
  amo_alu u_alu (.op(op_q), .old(rdata_q), .wdata(wdata_q), .result(alu_result));
  assign mem_rd_req = state_q == READ;
  assign mem_wr_req = state_q == WRITE;
  assign mem_addr   = (mem_rd_req || mem_wr_req) ? {word_q, 2'b00} : '0;
  assign mem_wdata  = mem_wr_req ? alu_result : '0;
  assign rsp_valid  = state_q == RESP;
  assign rsp_rdata  = rsp_valid ? rdata_q : '0;
  assign rsp_id     = rsp_valid ? id_q : '0;
  assign rsp_err    = rsp_valid && err_q;
endmodule

// File: tb/tb_amo_responder.sv
// tb_amo_responder: random AMO traffic against a transaction-level model plus directed corner cases.
module tb_amo_responder;
  import riscv_types::*;
`ifdef AMO_LRSC_EN
  localparam bit LRSC = 1'b1;
`else
  localparam bit LRSC = 1'b0;
`endif
  logic clk, rst_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [4:0] req_op;
  logic [31:0] req_addr, req_wdata, rsp_rdata, mem_rdata, mem_wdata, mem_addr, snoop_wr_addr;
  logic [1:0] req_id, rsp_id;
  logic mem_rd_req, mem_rd_ack, mem_wr_req, mem_wr_ack, snoop_wr_valid;

  amo_responder #(.ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_id(req_id), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack), .mem_rdata(mem_rdata),
    .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .snoop_wr_valid(snoop_wr_valid), .snoop_wr_addr(snoop_wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [4:0] ops [11] = '{AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
                           AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU};
  logic [31:0] mem [logic [29:0]];
  function automatic logic [31:0] rd(input logic [29:0] w);
    return mem.exists(w) ? mem[w] : {w, 2'b11};
  endfunction
  function automatic bit legal(input logic [4:0] op);
    foreach (ops[i]) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [31:0] f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      AMO_ADD:  return a + b;
      AMO_XOR:  return a ^ b;
      AMO_AND:  return a & b;
      AMO_OR:   return a | b;
      AMO_MIN:  return ($signed(a) < $signed(b)) ? a : b;
      AMO_MAX:  return ($signed(a) < $signed(b)) ? b : a;
      AMO_MINU: return (a < b) ? a : b;
      AMO_MAXU: return (a < b) ? b : a;
      default:  return b;
    endcase
  endfunction

  // transaction-level model state
  bit busy = 0, exp_rd, exp_wr, exp_err, rd_done, wr_done, resv_v = 0;
  logic [31:0] exp_wdata, exp_rdata, last_rdata;
  logic last_err;
  logic [29:0] cur_w, resv_w;
  logic [4:0] cur_op;
  logic [1:0] exp_id;
  int cyc = 0, acc_cyc = 0, rsp_cyc = 0, rd_cnt = 0, wr_cnt = 0;

  always @(posedge clk) begin : mdl
    logic [29:0] w;
    bit ok;
    cyc++;
    if (!rst_n) begin
      busy = 0;
      resv_v = 0;
    end else begin
      if (busy && mem_rd_req && mem_rd_ack) begin
        rd_done = 1;
        rd_cnt++;
      end
      if (busy && mem_rd_req && mem_rd_ack && cur_op == AMO_LR) begin
        resv_v = !(snoop_wr_valid && snoop_wr_addr[31:2] == cur_w);
        resv_w = cur_w;
      end else if (snoop_wr_valid && snoop_wr_addr[31:2] == resv_w) resv_v = 0;
      if (mem_wr_req && mem_wr_ack) begin
        wr_done = 1;
        wr_cnt++;
        mem[mem_addr[31:2]] = mem_wdata;
      end
      if (busy && rsp_valid && rsp_ready) begin
        chk("read_before_rsp", 32'(rd_done), 32'(exp_rd));
        chk("write_before_rsp", 32'(wr_done), 32'(exp_wr));
        last_rdata = rsp_rdata;
        last_err = rsp_err;
        rsp_cyc = cyc;
        busy = 0;
      end
      if (req_valid && req_ready) begin
        w = req_addr[31:2];
        cur_w = w;
        cur_op = req_op;
        exp_id = req_id;
        exp_err = req_addr[1:0] != 2'b00 || !legal(req_op);
        {rd_done, wr_done, exp_rd, exp_wr} = 4'b0;
        exp_rdata = 0;
        exp_wdata = 0;
        if (!exp_err && req_op == AMO_SC) begin
          ok = LRSC && resv_v && resv_w == w && !(snoop_wr_valid && snoop_wr_addr[31:2] == w);
          exp_wr = ok;
          exp_wdata = req_wdata;
          exp_rdata = ok ? 32'd0 : 32'd1;
        end else if (!exp_err) begin
          exp_rd = 1;
          exp_rdata = rd(w);
          exp_wr = req_op != AMO_LR;
          exp_wdata = f(req_op, rd(w), req_wdata);
        end
        if (req_op == AMO_SC) resv_v = 0;
        busy = 1;
        acc_cyc = cyc;
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit exp_rv;
    if (rst_n) begin
      exp_rv = busy && (!exp_rd || rd_done) && (!exp_wr || wr_done);
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("mem_rd_req", 32'(mem_rd_req), 32'(busy && exp_rd && !rd_done));
      chk("mem_wr_req", 32'(mem_wr_req), 32'(busy && exp_wr && (!exp_rd || rd_done) && !wr_done));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("mem_addr", mem_addr, (mem_rd_req || mem_wr_req) ? {cur_w, 2'b00} : 32'd0);
      if (mem_wr_req) chk("mem_wdata", mem_wdata, exp_wdata);
      if (rsp_valid) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_id", 32'(rsp_id), 32'(exp_id));
      end
    end
  end

  int ack_pct = 100, rdy_pct = 100, snoop_pct = 0;
  bit force_snoop = 0;
  logic [31:0] force_addr = 0;
  initial begin
    {mem_rd_ack, mem_wr_ack, rsp_ready, snoop_wr_valid} = 4'b0;
    mem_rdata = 0;
    snoop_wr_addr = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_rd_ack = ($urandom % 100) < ack_pct;
      mem_wr_ack = ($urandom % 100) < ack_pct;
      rsp_ready = ($urandom % 100) < rdy_pct;
      mem_rdata = rd(mem_addr[31:2]);
      snoop_wr_valid = force_snoop || (($urandom % 100) < snoop_pct);
      snoop_wr_addr = force_snoop ? force_addr : 32'h200 + ($urandom % 16);
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] id);
    bit r, got;
    got = 0;
    @(posedge clk);
    #1;
    req_valid = 1;
    req_op = op;
    req_addr = a;
    req_wdata = wd;
    req_id = id;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      r = req_ready;
      @(posedge clk);
      got = r;
    end
    #1 req_valid = 0;
    chk("accepted", 32'(got), 32'd1);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    chk("completed", 32'(busy), 32'd0);
  endtask
  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] id);
    issue(op, a, wd, id);
    wait_done();
  endtask

  initial begin
    int w0, r0;
    logic [4:0] op;
    logic [31:0] a;
    rst_n = 0;
    req_valid = 0;
    req_op = 0;
    req_addr = 0;
    req_wdata = 0;
    req_id = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rd_req", 32'(mem_rd_req), 0);
    chk("rst_wr_req", 32'(mem_wr_req), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1;
    #1 chk("rst_req_ready", 32'(req_ready), 1);
    mem[30'h40] = 32'h7FFFFFFF;
    run(AMO_ADD, 32'h100, 32'h1, 2'd1);
    chk("add_mem", mem[30'h40], 32'h80000000);
    chk("add_rsp", last_rdata, 32'h7FFFFFFF);
    chk("min_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
    mem[30'h41] = 32'h5;
    run(AMO_MIN, 32'h104, 32'hFFFFFFFF, 2'd2);
    chk("min_mem", mem[30'h41], 32'hFFFFFFFF);
    mem[30'h41] = 32'h5;
    run(AMO_MINU, 32'h104, 32'hFFFFFFFF, 2'd3);
    chk("minu_mem", mem[30'h41], 32'h5);
    mem[30'h80] = 32'h55;
    run(AMO_LR, 32'h200, 32'h0, 2'd0);
    chk("lr_rsp", last_rdata, 32'h55);
    w0 = wr_cnt;
    run(AMO_SC, 32'h200, 32'hAB, 2'd1);
    chk("sc1_rsp", last_rdata, LRSC ? 32'd0 : 32'd1);
    chk("sc1_mem", mem[30'h80], LRSC ? 32'hAB : 32'h55);
    chk("sc1_writes", 32'(wr_cnt - w0), LRSC ? 32'd1 : 32'd0);
    w0 = wr_cnt;
    run(AMO_SC, 32'h200, 32'hCD, 2'd2);
    chk("sc2_rsp", last_rdata, 32'd1);
    chk("sc2_writes", 32'(wr_cnt - w0), 32'd0);
    run(AMO_LR, 32'h200, 32'h0, 2'd0);
    force_addr = 32'h200;
    force_snoop = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    force_snoop = 0;
    w0 = wr_cnt;
    run(AMO_SC, 32'h200, 32'h77, 2'd3);
    chk("snoop_sc_rsp", last_rdata, 32'd1);
    chk("snoop_sc_writes", 32'(wr_cnt - w0), 32'd0);
    rdy_pct = 0;
    r0 = rd_cnt;
    issue(AMO_ADD, 32'h102, 32'h5, 2'd2);
    repeat (4) @(negedge clk);
    chk("misalign_held_valid", 32'(rsp_valid), 32'd1);
    chk("misalign_held_err", 32'(rsp_err), 32'd1);
    rdy_pct = 100;
    wait_done();
    chk("misalign_err", 32'(last_err), 32'd1);
    chk("misalign_rdata", last_rdata, 32'd0);
    chk("misalign_no_read", 32'(rd_cnt - r0), 32'd0);
    ack_pct = 0;
    issue(AMO_ADD, 32'h108, 32'h3, 2'd3);
    repeat (3) @(negedge clk);
    chk("pre_rst_rd_req", 32'(mem_rd_req), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_rd_req", 32'(mem_rd_req), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1;
    ack_pct = 100;
    repeat (3) @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 4; i++) mem[30'h80 + 30'(i)] = $urandom;
    snoop_pct = 10;
    for (int n = 0; n < 400; n++) begin
      if (n % 25 == 0) begin
        ack_pct = 30 + $urandom % 71;
        rdy_pct = 30 + $urandom % 71;
      end
      case ($urandom % 10)
        0, 1, 2: op = AMO_LR;
        3, 4:    op = AMO_SC;
        5:       op = ($urandom % 2) ? 5'b00101 : 5'b11111;
        default: op = ops[$urandom % 11];
      endcase
      a = 32'h200 + 4 * ($urandom % 4);
      if ($urandom % 10 == 0) a = a + 1 + $urandom % 3;
      run(op, a, $urandom, 2'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/amo_responder.md
AMO_RESPONDER -- requirements
Module: amo_responder

Interface
REQ-001 SHALL have parameter ID_W, default 2, request/response tag width.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  AMO request offered.
REQ-005 SHALL have port req_ready  out  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_op  in  5  amo_t operation.
REQ-007 SHALL have port req_addr  in  32  byte address, word-aligned required.
REQ-008 SHALL have port req_wdata  in  32  rs2 operand.
REQ-009 SHALL have port req_id  in  ID_W  tag echoed on response.
REQ-010 SHALL have port rsp_valid  out  1  response offered.
REQ-011 SHALL have port rsp_ready  in  1  response consumed.
REQ-012 SHALL have port rsp_rdata, rsp_id, rsp_err  out  32/ID_W/1  result, tag, error.
REQ-013 SHALL have port mem_rd_req  out  1, mem_rd_ack  in  1, mem_rdata  in  32  memory read.
REQ-014 SHALL have port mem_wr_req  out  1, mem_wr_ack  in  1, mem_wdata  out  32  memory write.
REQ-015 SHALL have port mem_addr  out  32  word address of current access.
REQ-016 SHALL have port snoop_wr_valid  in  1, snoop_wr_addr  in  32  write by another master.

Function
REQ-017 SHALL implement states IDLE, READ, WRITE, RESP; req_ready = (state==IDLE).
REQ-018 On accept SHALL latch op/addr/wdata/id; next cycle enter READ (SC: see REQ-023).
REQ-019 Misaligned addr (addr[1:0]!=0) or op not in amo_t SHALL go directly to RESP with rsp_err=1, rsp_rdata=0, no memory access.
REQ-020 READ SHALL hold mem_rd_req until mem_rd_ack; capture mem_rdata that cycle; go WRITE (LR: go RESP).
REQ-021 WRITE SHALL hold mem_wr_req, mem_wdata=f(old,wdata) until mem_wr_ack; then RESP.
REQ-022 f: SWAP=wdata; ADD=old+wdata mod 2^32; XOR/AND/OR bitwise; MIN/MAX signed; MINU/MAXU unsigned.
REQ-023 SC SHALL skip READ: reservation valid and matching -> WRITE wdata, rsp_rdata=0; else RESP, rsp_rdata=1, no write.
REQ-024 Non-SC response rsp_rdata SHALL be old memory value; rsp_err=0.
REQ-025 RESP SHALL hold rsp_valid and stable data until rsp_ready; then IDLE; no new accept in that cycle.
REQ-026 mem_addr SHALL be {addr[31:2],2'b00} in READ/WRITE, 0 otherwise.
REQ-027 Minimum latency (acks same cycle as requests, rsp_ready high): read-modify-write 4 cycles accept->response consumed.
REQ-028 Reservation SHALL be set (valid, word address) on LR mem_rd_ack; cleared by any SC completion and by snoop_wr_valid to same word.
REQ-029 Snoop matching the LR address in the same cycle as LR mem_rd_ack SHALL leave reservation invalid (snoop wins).
REQ-030 Snoop matching during SC WRITE SHALL not abort the in-flight write.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, reservation invalid, req_ready=1 after release, all other outputs 0.
REQ-032 Reset mid-operation SHALL drop outstanding memory request without response.

Configuration
REQ-033 With AMO_LRSC_EN defined SHALL implement reservation per REQ-023/028-030.
REQ-034 Without AMO_LRSC_EN SHALL treat LR as plain read and SC always fail (rsp_rdata=1, no write), no reservation storage.

Structure
REQ-035 amo_t remains in riscv_types; amo_state_t (IDLE/READ/WRITE/RESP) SHALL be added to riscv_types.
REQ-036 Combinational f SHALL be sub-module amo_alu (op, old, wdata -> result).

Verification
REQ-037 AMO_ADD addr 0x100, mem=0x7FFFFFFF, wdata=1 -> write 0x80000000, rsp_rdata 0x7FFFFFFF.
REQ-038 AMO_MIN mem=0x00000005, wdata=0xFFFFFFFF -> write 0xFFFFFFFF; AMO_MINU same operands -> write 0x00000005.
REQ-039 LR 0x200, then SC 0x200 wdata 0xAB -> write 0xAB, rsp 0; second SC -> rsp 1, no write.
REQ-040 LR 0x200, snoop 0x200, SC 0x200 -> rsp 1, mem_wr_req never high.
REQ-041 Request addr 0x102 -> rsp_err=1 next state, no mem_rd_req; rsp_ready low 3 cycles keeps response stable.
REQ-042 rst_n low while mem_rd_req waits for ack -> mem_rd_req 0 immediately, IDLE, no rsp_valid.
